// File: rtl/simon_input_conditioner.sv
// Simon game input front end: 2-flop synchronisers, per-input debouncers and a
// one-key-at-a-time press FSM producing the controller's strobes and colour decodes.
module simon_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       enter_raw,
    input  logic [1:0] expected,
    output logic [1:0] key_code,
    output logic       key_pressed,
    output logic       key_released,
    output logic       valid_input,
    output logic       enter_pressed,
    output logic       input_eq_green,
    output logic       input_eq_red,
    output logic       input_eq_yellow,
    output logic       input_eq_blue,
    output logic       correct
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The D-th consecutive disagreeing cycle flips the level, so compare against D-1.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StWaitClear
    } state_e;

    // Bit 4 is ENTER, bits 3:0 are the colour buttons.
    logic [4:0]            raw_all;
    logic [4:0]            sync1_q;
    logic [4:0]            sync2_q;
    logic [4:0]            db_q;
    logic [4:0]            db_d;
    logic [4:0][CNT_W-1:0] cnt_q;
    logic [4:0][CNT_W-1:0] cnt_d;

    state_e     state_q;
    state_e     state_d;
    logic [1:0] key_code_q;
    logic [1:0] key_code_d;
    logic       key_pressed_q;
    logic       key_pressed_d;
    logic       key_released_q;
    logic       key_released_d;
    logic       valid_q;
    logic       valid_d;
    logic       enter_pressed_q;
    logic       enter_pressed_d;
    logic       enter_last_q;

    logic [3:0] db_color;
    logic       color_single;
    logic       color_none;
    logic [1:0] color_code;
    logic [3:0] key_mask;

    assign raw_all = {enter_raw, btn_raw};

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign db_color     = db_q[3:0];
    assign color_none   = (db_color == 4'b0000);
    assign color_single = !color_none && ((db_color & (db_color - 4'd1)) == 4'b0000);
    assign key_mask     = 4'b0001 << key_code_q;

    always_comb begin
        color_code = 2'd0;
        unique case (db_color)
            4'b0001: color_code = 2'd0;
            4'b0010: color_code = 2'd1;
            4'b0100: color_code = 2'd2;
            4'b1000: color_code = 2'd3;
            default: color_code = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        key_code_d     = key_code_q;
        key_pressed_d  = 1'b0;
        key_released_d = 1'b0;
        valid_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (color_single) begin
                    state_d       = StHeld;
                    key_code_d    = color_code;
                    key_pressed_d = 1'b1;
                    valid_d       = 1'b1;
                end else if (!color_none) begin
                    state_d = StWaitClear;
                end
            end
            StHeld: begin
                if (color_none) begin
                    // Keep valid through the release cycle so correct can be sampled there.
                    state_d        = StIdle;
                    key_released_d = 1'b1;
                    valid_d        = 1'b1;
                end else if (db_color != key_mask) begin
                    state_d        = StWaitClear;
                    key_released_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            StWaitClear: begin
                if (color_none) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_pressed_d = db_q[4] & ~enter_last_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            db_q            <= '0;
            cnt_q           <= '0;
            state_q         <= StIdle;
            key_code_q      <= 2'd0;
            key_pressed_q   <= 1'b0;
            key_released_q  <= 1'b0;
            valid_q         <= 1'b0;
            enter_pressed_q <= 1'b0;
            enter_last_q    <= 1'b0;
        end else begin
            sync1_q         <= raw_all;
            sync2_q         <= sync1_q;
            db_q            <= db_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            key_code_q      <= key_code_d;
            key_pressed_q   <= key_pressed_d;
            key_released_q  <= key_released_d;
            valid_q         <= valid_d;
            enter_pressed_q <= enter_pressed_d;
            enter_last_q    <= db_q[4];
        end
    end

    assign key_code        = key_code_q;
    assign key_pressed     = key_pressed_q;
    assign key_released    = key_released_q;
    assign valid_input     = valid_q;
    assign enter_pressed   = enter_pressed_q;
    assign input_eq_green  = valid_q & (key_code_q == 2'd0);
    assign input_eq_red    = valid_q & (key_code_q == 2'd1);
    assign input_eq_yellow = valid_q & (key_code_q == 2'd2);
    assign input_eq_blue   = valid_q & (key_code_q == 2'd3);
    assign correct         = valid_q & (key_code_q == expected);

endmodule
